l2_port_arbiter: RTL and testbench

//  Shares the single-port L2 SRAM between N_MASTERS TCDM-style requesters.

---
 rtl/l2_arb_pkg.sv | 36 +++
 rtl/l2_port_arbiter_if.sv | 47 ++++
 rtl/l2_rr_arbiter.sv | 56 +++++
 rtl/l2_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arb_pkg.sv
// -----------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and constants for the L2 port arbiter.
//   lock_state_e  : bus-lock FSM states (UNLOCKED / LOCKED)
//   mst_idx_t     : master index, sized for the largest supported master count
//   JTAG_MST_IDX  : index of the JTAG debug bridge requester
//   next_idx()    : round-robin successor of an index, wrapping at n
// -----------------------------------------------------------------------------
package l2_arb_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Index type covers up to 8 masters so one type serves every legal
    // N_MASTERS without the package having to be parameterised.
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned MST_IDX_W   = $clog2(MAX_MASTERS);

    typedef logic [MST_IDX_W-1:0] mst_idx_t;

    localparam mst_idx_t JTAG_MST_IDX = mst_idx_t'(0);

    // Successor of idx in a ring of n entries.
    function automatic mst_idx_t next_idx(input mst_idx_t idx, input int unsigned n);
        mst_idx_t nxt;
        if (idx >= mst_idx_t'(n - 32'd1)) begin
            nxt = mst_idx_t'(0);
        end else begin
            nxt = idx + mst_idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter_if
// Bus bundle between the requesters, the arbiter and the single-port L2 SRAM.
//   m_*    : per-master TCDM-style request / grant / response signals
//   mem_*  : SRAM-side request and read data
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the SRAM)
//   master : the environment's view (requesters plus SRAM model)
// -----------------------------------------------------------------------------
interface l2_port_arbiter_if
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [N_MASTERS-1:0]             m_req_i;
    logic [N_MASTERS-1:0]             m_we_i;
    logic [N_MASTERS-1:0][BE_W-1:0]   m_be_i;
    logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr_i;
    logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata_i;
    logic [N_MASTERS-1:0]             m_lock_i;
    logic [N_MASTERS-1:0]             m_gnt_o;
    logic [N_MASTERS-1:0]             m_rvalid_o;
    logic [DATA_W-1:0]                m_rdata_o;
    logic                             mem_req_o;
    logic                             mem_we_o;
    logic [BE_W-1:0]                  mem_be_o;
    logic [ADDR_W-1:0]                mem_addr_o;
    logic [DATA_W-1:0]                mem_wdata_o;
    logic [DATA_W-1:0]                mem_rdata_i;

    modport slave (
        input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, m_lock_i, mem_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, m_lock_i, mem_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/l2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// l2_rr_arbiter
// Purely combinational round-robin picker.
//   req_i    : request vector
//   mask_i   : eligibility mask (all ones unless a lock restricts the winner)
//   rr_ptr_i : highest-priority index this cycle (must be < N_MASTERS)
//   gnt_o    : one-hot grant, zero when nothing eligible
//   winner_o : index of the granted requester
//   valid_o  : a grant was issued
// -----------------------------------------------------------------------------
module l2_rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [N_MASTERS-1:0] mask_i,
    input  mst_idx_t             rr_ptr_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output mst_idx_t             winner_o,
    output logic                 valid_o
);
    // One spare bit so rr_ptr + offset cannot overflow before the wrap.
    localparam int unsigned SUM_W = MST_IDX_W + 1;

    logic [N_MASTERS-1:0] elig_s;
    logic [SUM_W-1:0]     cand_s;
    logic                 hit_s;
    logic                 take_s;

    // Scan candidates rr_ptr, rr_ptr+1, ... (mod N) and keep the first eligible one.
    always_comb begin
        elig_s   = req_i & mask_i;
        valid_o  = 1'b0;
        winner_o = mst_idx_t'(0);
        cand_s   = {SUM_W{1'b0}};
        hit_s    = 1'b0;
        take_s   = 1'b0;
        gnt_o    = {N_MASTERS{1'b0}};
        for (int off = 0; off < int'(N_MASTERS); off++) begin
            cand_s = SUM_W'(rr_ptr_i) + SUM_W'(off);
            cand_s = (cand_s >= SUM_W'(N_MASTERS)) ? (cand_s - SUM_W'(N_MASTERS)) : cand_s;
            hit_s  = 1'b0;
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                hit_s = hit_s | (elig_s[i] & (cand_s == SUM_W'(i)));
            end
            take_s   = hit_s & ~valid_o;
            winner_o = take_s ? cand_s[MST_IDX_W-1:0] : winner_o;
            valid_o  = valid_o | hit_s;
        end
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            gnt_o[i] = valid_o & (winner_o == mst_idx_t'(i));
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
// Shares the single-port L2 SRAM between N_MASTERS requesters (index 0 is the
// JTAG debug bridge). Round-robin grant, optional bounded bus lock, and a
// 1-cycle response path routed back to the granted master.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous reset, active high
//   bus    : l2_port_arbiter_if.slave (master requests/responses, SRAM side)
//   busy_o : a response is pending or a lock is held
// Build option:
//   L2_ARB_JTAG_PRIO_EN : master 0 preempts everything, including an active
//                         lock; the lock is only suspended for that cycle and
//                         neither lock_cnt nor rr_ptr move on a master-0 grant.
// -----------------------------------------------------------------------------
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LOCK_MAX  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    l2_port_arbiter_if.slave   bus,
    output logic               busy_o
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_e          state_q, state_d;
    mst_idx_t             lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    mst_idx_t             rr_ptr_q, rr_ptr_d;
    logic                 rsp_v_q, rsp_v_d;
    mst_idx_t             rsp_id_q, rsp_id_d;

    logic                 owner_req_s;
    logic                 owner_lock_s;
    logic                 lock_hold_s;
    logic                 jtag_req_s;
    logic                 jtag_ovr_s;
    logic [N_MASTERS-1:0] arb_mask_s;
    logic [N_MASTERS-1:0] arb_gnt_s;
    mst_idx_t             arb_win_s;
    logic                 arb_valid_s;
    logic [N_MASTERS-1:0] gnt_s;
    mst_idx_t             win_s;
    logic                 gnt_any_s;
    logic                 win_lock_s;
    logic                 rsp_live_s;

    // Lock continuation: release conditions on the owner are evaluated before
    // arbitration, so a released lock lets everyone compete this same cycle.
    always_comb begin
        owner_req_s  = 1'b0;
        owner_lock_s = 1'b0;
        jtag_req_s   = 1'b0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            owner_req_s  = owner_req_s  | (bus.m_req_i[i]  & (lock_owner_q == mst_idx_t'(i)));
            owner_lock_s = owner_lock_s | (bus.m_lock_i[i] & (lock_owner_q == mst_idx_t'(i)));
            jtag_req_s   = jtag_req_s   | (bus.m_req_i[i]  & (JTAG_MST_IDX == mst_idx_t'(i)));
        end
        lock_hold_s = (state_q == LOCKED) & owner_req_s & owner_lock_s;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            arb_mask_s[i] = ~lock_hold_s | (lock_owner_q == mst_idx_t'(i));
        end
    end

`ifdef L2_ARB_JTAG_PRIO_EN
    assign jtag_ovr_s = jtag_req_s & ~rst_i;
`else
    assign jtag_ovr_s = 1'b0;
`endif

    l2_rr_arbiter #(
        .N_MASTERS (N_MASTERS)
    ) u_rr (
        .req_i    (bus.m_req_i),
        .mask_i   (arb_mask_s),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt_s),
        .winner_o (arb_win_s),
        .valid_o  (arb_valid_s)
    );

    // Final grant: nothing in reset, JTAG override when enabled, else RR result.
    always_comb begin
        gnt_s     = {N_MASTERS{1'b0}};
        win_s     = mst_idx_t'(0);
        gnt_any_s = 1'b0;
        if (rst_i) begin
            gnt_any_s = 1'b0;
        end else if (jtag_ovr_s) begin
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                gnt_s[i] = (JTAG_MST_IDX == mst_idx_t'(i));
            end
            win_s     = JTAG_MST_IDX;
            gnt_any_s = 1'b1;
        end else begin
            gnt_s     = arb_gnt_s;
            win_s     = arb_win_s;
            gnt_any_s = arb_valid_s;
        end
    end

    assign bus.m_gnt_o   = gnt_s;
    assign bus.mem_req_o = gnt_any_s;

    // SRAM request mux: AND-OR over the one-hot grant, all zero when idle.
    always_comb begin
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = {BE_W{1'b0}};
        bus.mem_addr_o  = {ADDR_W{1'b0}};
        bus.mem_wdata_o = {DATA_W{1'b0}};
        win_lock_s      = 1'b0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            bus.mem_we_o    = bus.mem_we_o    | (gnt_s[i] & bus.m_we_i[i]);
            bus.mem_be_o    = bus.mem_be_o    | ({BE_W{gnt_s[i]}}   & bus.m_be_i[i]);
            bus.mem_addr_o  = bus.mem_addr_o  | ({ADDR_W{gnt_s[i]}} & bus.m_addr_i[i]);
            bus.mem_wdata_o = bus.mem_wdata_o | ({DATA_W{gnt_s[i]}} & bus.m_wdata_i[i]);
            win_lock_s      = win_lock_s      | (gnt_s[i] & bus.m_lock_i[i]);
        end
    end

    // Next state for lock FSM, rr pointer and response pipeline.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_v_d      = gnt_any_s;
        rsp_id_d     = win_s;
        if (jtag_ovr_s) begin
            // Lock is suspended, not released; pointer and count are frozen.
            state_d = state_q;
        end else if (lock_hold_s) begin
            rr_ptr_d = next_idx(win_s, N_MASTERS);
            if (lock_cnt_q == CNT_W'(LOCK_MAX - 32'd1)) begin
                // Forced release; rr_ptr already points past the owner.
                state_d      = UNLOCKED;
                lock_owner_d = mst_idx_t'(0);
                lock_cnt_d   = {CNT_W{1'b0}};
            end else begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end
        end else begin
            state_d      = UNLOCKED;
            lock_owner_d = mst_idx_t'(0);
            lock_cnt_d   = {CNT_W{1'b0}};
            if (gnt_any_s) begin
                rr_ptr_d = next_idx(win_s, N_MASTERS);
                if (win_lock_s && (LOCK_MAX > 32'd1)) begin
                    state_d      = LOCKED;
                    lock_owner_d = win_s;
                    lock_cnt_d   = CNT_W'(1);
                end else begin
                    state_d = UNLOCKED;
                end
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= UNLOCKED;
            lock_owner_q <= mst_idx_t'(0);
            lock_cnt_q   <= {CNT_W{1'b0}};
            rr_ptr_q     <= mst_idx_t'(0);
            rsp_v_q      <= 1'b0;
            rsp_id_q     <= mst_idx_t'(0);
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_v_q      <= rsp_v_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // A response still in flight when reset arrives is suppressed, not emitted.
    assign rsp_live_s = rsp_v_q & ~rst_i;

    // Response routing back to the master granted last cycle.
    always_comb begin
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            bus.m_rvalid_o[i] = rsp_live_s & (rsp_id_q == mst_idx_t'(i));
        end
        bus.m_rdata_o = rsp_live_s ? bus.mem_rdata_i : {DATA_W{1'b0}};
    end

    assign busy_o = ~rst_i & (rsp_v_q | (state_q == LOCKED));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_port_arbiter
// Directed scenarios plus randomized traffic for l2_port_arbiter, every cycle
// compared against a behavioural model of the arbitration, lock and response
// rules. A small SRAM model answers the arbiter's memory requests.
// -----------------------------------------------------------------------------
module tb_l2_port_arbiter;

    localparam int N        = 2;
    localparam int LOCK_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    l2_port_arbiter_if #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) bus ();

    l2_port_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (32),
        .DATA_W    (32),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM environment: 4 words, returns the pre-write word one cycle later.
    logic [31:0] sram [4] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            bus.mem_rdata_i <= sram[bus.mem_addr_o[3:2]];
            if (bus.mem_we_o)
                sram[bus.mem_addr_o[3:2]] <= merge(sram[bus.mem_addr_o[3:2]], bus.mem_wdata_o, bus.mem_be_o);
        end else begin
            bus.mem_rdata_i <= 32'h0;
        end
    end

    // Stimulus for the next cycle
    logic                  st_rst;
    logic [N-1:0]          st_req, st_lock, st_we;
    logic [N-1:0][3:0]     st_be;
    logic [N-1:0][31:0]    st_addr, st_wdata;

    // Last observed outputs
    logic [N-1:0]          last_gnt, last_rv;
    logic [31:0]           last_rdata;
    logic                  last_busy, last_memreq;

    // Reference model state
    int          m_ptr, m_owner, m_cnt, m_pend_id;
    bit          m_locked, m_pend_v;
    logic [31:0] m_pend_data;
    logic [31:0] mdl_mem [4] = '{default: 32'h0};

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        st_rst = 1'b0; st_req = '0; st_lock = '0; st_we = '0;
        st_be = '0; st_addr = '0; st_wdata = '0;
    endtask

    // One clock cycle: apply stimulus, compare against model, advance model.
    task automatic step();
        int          win, widx;
        bit          prio, hold;
        logic [N-1:0] e_gnt, e_rv;
        logic [31:0] e_rdata, e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we, e_busy;
        @(negedge clk);
        rst           = st_rst;
        bus.m_req_i   = st_req;
        bus.m_lock_i  = st_lock;
        bus.m_we_i    = st_we;
        bus.m_be_i    = st_be;
        bus.m_addr_i  = st_addr;
        bus.m_wdata_i = st_wdata;
        #1;
        win = -1; prio = 1'b0; hold = 1'b0;
        e_gnt = '0; e_rv = '0; e_rdata = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
        e_be = 4'h0; e_we = 1'b0; e_busy = 1'b0;
        if (!st_rst) begin
            if (m_pend_v) begin
                e_rv[m_pend_id] = 1'b1;
                e_rdata = m_pend_data;
            end
            e_busy = m_pend_v || m_locked;
`ifdef L2_ARB_JTAG_PRIO_EN
            prio = st_req[0];
`endif
            if (prio) begin
                win = 0;
            end else begin
                hold = m_locked && st_req[m_owner] && st_lock[m_owner];
                if (hold) win = m_owner;
                else
                    for (int k = 0; k < N; k++)
                        if (win < 0 && st_req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                e_gnt[win] = 1'b1;
                e_we = st_we[win]; e_be = st_be[win];
                e_addr = st_addr[win]; e_wdata = st_wdata[win];
            end
        end
        last_gnt = bus.m_gnt_o; last_rv = bus.m_rvalid_o; last_rdata = bus.m_rdata_o;
        last_busy = busy; last_memreq = bus.mem_req_o;
        chk("gnt",      64'(bus.m_gnt_o),     64'(e_gnt));
        chk("mem_req",  64'(bus.mem_req_o),   64'(win >= 0));
        chk("mem_we",   64'(bus.mem_we_o),    64'(e_we));
        chk("mem_be",   64'(bus.mem_be_o),    64'(e_be));
        chk("mem_addr", 64'(bus.mem_addr_o),  64'(e_addr));
        chk("mem_wd",   64'(bus.mem_wdata_o), 64'(e_wdata));
        chk("rvalid",   64'(bus.m_rvalid_o),  64'(e_rv));
        chk("rdata",    64'(bus.m_rdata_o),   64'(e_rdata));
        chk("busy",     64'(busy),            64'(e_busy));
        if (st_rst) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0; m_pend_v = 1'b0;
        end else begin
            if (!prio && !hold) begin m_locked = 1'b0; m_cnt = 0; end
            if (win >= 0) begin
                widx = int'(st_addr[win][3:2]);
                m_pend_v = 1'b1; m_pend_id = win; m_pend_data = mdl_mem[widx];
                if (st_we[win]) mdl_mem[widx] = merge(mdl_mem[widx], st_wdata[win], st_be[win]);
                if (!prio) begin
                    m_ptr = (win + 1) % N;
                    if (hold) begin
                        m_cnt++;
                        if (m_cnt == LOCK_MAX) begin m_locked = 1'b0; m_cnt = 0; end
                    end else if (st_lock[win] && LOCK_MAX > 1) begin
                        m_locked = 1'b1; m_owner = win; m_cnt = 1;
                    end
                end
            end else begin
                m_pend_v = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        idle(); st_rst = 1'b1; step(); st_rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] prev;
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_pend_id = 0;
        m_locked = 1'b0; m_pend_v = 1'b0; m_pend_data = 32'h0;
        idle();

        // Reset held with all masters requesting
        st_rst = 1'b1; st_req = '1;
        repeat (3) begin
            step();
            chk("t1_gnt", 64'(last_gnt), 64'h0);
            chk("t1_rv",  64'(last_rv),  64'h0);
            chk("t1_mreq", 64'(last_memreq), 64'h0);
        end
        st_rst = 1'b0;
        step();
        chk("t1_first", 64'(last_gnt), 64'h1);

`ifndef L2_ARB_JTAG_PRIO_EN
        // Continuous requests alternate; rvalid echoes the previous grant
        do_reset();
        st_req = '1;
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t2_gnt", 64'(last_gnt), (c % 2 == 0) ? 64'h1 : 64'h2);
            if (c > 0) chk("t2_rv", 64'(last_rv), 64'(prev));
            prev = last_gnt;
        end
`endif

        // Write then read back through master 0
        do_reset();
        st_req = 2'b01; st_we = 2'b01; st_be[0] = 4'hF; st_addr[0] = 32'h0;
        st_wdata[0] = 32'hABBA_ABBA;
        step();
        chk("t3_wgnt", 64'(last_gnt), 64'h1);
        st_we = 2'b00;
        step();
        chk("t3_rgnt", 64'(last_gnt), 64'h1);
        idle();
        step();
        chk("t3_rv",    64'(last_rv),    64'h1);
        chk("t3_rdata", 64'(last_rdata), 64'hABBA_ABBA);

`ifndef L2_ARB_JTAG_PRIO_EN
        // Bounded lock: 16 grants to master 1, one to master 0, master 1 relocks
        do_reset();
        st_req = 2'b01; step();
        st_req = 2'b11; st_lock = 2'b10;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t4_gnt", 64'(last_gnt), (c == 16) ? 64'h1 : 64'h2);
        end
`endif

        // Reset right after a read grant swallows the response
        do_reset();
        st_req = 2'b01; step();
        chk("t5_gnt", 64'(last_gnt), 64'h1);
        idle(); st_rst = 1'b1; step();
        chk("t5_rv", 64'(last_rv), 64'h0);
        st_rst = 1'b0; step();
        chk("t5_busy", 64'(last_busy), 64'h0);
        chk("t5_rv2",  64'(last_rv),   64'h0);

`ifdef L2_ARB_JTAG_PRIO_EN
        // JTAG preempts an active lock for exactly one cycle
        do_reset();
        st_lock = 2'b10;
        for (int c = 0; c < 20; c++) begin
            st_req = (c == 5) ? 2'b11 : 2'b10;
            step();
            chk("t6_gnt", 64'(last_gnt), (c == 5) ? 64'h1 : 64'h2);
        end
`endif

        // Randomized traffic with sticky request/lock patterns
        do_reset();
        for (int c = 0; c < 800; c++) begin
            st_rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) st_req[i]  = ~st_req[i];
                if ($urandom_range(0, 7) == 0) st_lock[i] = ~st_lock[i];
                st_we[i]    = 1'($urandom_range(0, 1));
                st_be[i]    = 4'($urandom);
                st_addr[i]  = $urandom & 32'hFFFF_FFFC;
                st_wdata[i] = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
